// File: rtl/bcd_countdown_timer_pkg.sv
// Shared state encodings, BCD digit limits and load sanitising helper
// for the MM:SS countdown timer.
package bcd_countdown_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    RING  = 2'd3
  } state_t;

  localparam logic [3:0] DIGIT_MAX    = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  // Out-of-range preset nibbles saturate at the digit's wrap value.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
    return (d > max) ? max : d;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_digit.sv
// One BCD down-counting digit: wraps 0 -> MAX when a borrow arrives,
// and passes that borrow on to the next more significant digit.
module bcd_down_digit
  import bcd_countdown_timer_pkg::*;
#(
  parameter logic [3:0] MAX = DIGIT_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       borrow_in,
  output logic [3:0] value,
  output logic       borrow_out
);

  logic [3:0] value_r;

  // Digit register: load wins over a decrement request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_r <= 4'd0;
    end else if (load) begin
      value_r <= load_val;
    end else if (borrow_in) begin
      value_r <= (value_r == 4'd0) ? MAX : (value_r - 4'd1);
    end else begin
      value_r <= value_r;
    end
  end

  assign value      = value_r;
  assign borrow_out = (value_r == 4'd0) & borrow_in;

endmodule

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer: four chained down-digits, a control FSM and a
// ring-duration counter advanced by the shared 1 Hz enable tick.
module bcd_countdown_timer
  import bcd_countdown_timer_pkg::*;
#(
  parameter int RING_TICKS = 30,
  parameter int RING_W     = 8
) (
  input  logic       CP,
  input  logic       nCR,
  input  logic       EN,
  input  logic       Load,
  input  logic [7:0] LoadMin,
  input  logic [7:0] LoadSec,
  input  logic       Start,
  input  logic       Stop,
  output logic [7:0] Min,
  output logic [7:0] Sec,
  output logic       Running,
  output logic       Ring,
  output logic       Done
);

  localparam logic [RING_W-1:0] RING_LOAD = RING_W'(RING_TICKS);

  state_t            state_r, state_nx;
  logic [RING_W-1:0] ring_cnt_r, ring_nx;
  logic              done_r;

  logic [3:0] sec_ones_s, sec_tens_s, min_ones_s, min_tens_s;
  logic       b_sec_ones_s, b_sec_tens_s, b_min_ones_s, b_min_tens_s;
  logic       count_zero_s, count_one_s, load_s, dec_s, expire_s;

  assign count_zero_s = ({min_tens_s, min_ones_s, sec_tens_s, sec_ones_s} == 16'h0000);
  assign count_one_s  = ({min_tens_s, min_ones_s, sec_tens_s, sec_ones_s} == 16'h0001);

  // Stop outranks Load; presets are accepted only while not counting or ringing.
  assign load_s   = Load & ~Stop & ((state_r == IDLE) | (state_r == PAUSE));
  assign dec_s    = (state_r == RUN) & EN & ~Stop & ~count_zero_s;
  assign expire_s = (state_r == RUN) & EN & ~Stop & count_one_s;

  bcd_down_digit #(.MAX(DIGIT_MAX)) u_sec_ones (
    .clk(CP), .rst_n(nCR), .load(load_s),
    .load_val(clamp_digit(LoadSec[3:0], DIGIT_MAX)),
    .borrow_in(dec_s), .value(sec_ones_s), .borrow_out(b_sec_ones_s)
  );

  bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk(CP), .rst_n(nCR), .load(load_s),
    .load_val(clamp_digit(LoadSec[7:4], SEC_TENS_MAX)),
    .borrow_in(b_sec_ones_s), .value(sec_tens_s), .borrow_out(b_sec_tens_s)
  );

  bcd_down_digit #(.MAX(DIGIT_MAX)) u_min_ones (
    .clk(CP), .rst_n(nCR), .load(load_s),
    .load_val(clamp_digit(LoadMin[3:0], DIGIT_MAX)),
    .borrow_in(b_sec_tens_s), .value(min_ones_s), .borrow_out(b_min_ones_s)
  );

  bcd_down_digit #(.MAX(DIGIT_MAX)) u_min_tens (
    .clk(CP), .rst_n(nCR), .load(load_s),
    .load_val(clamp_digit(LoadMin[7:4], DIGIT_MAX)),
    .borrow_in(b_min_ones_s), .value(min_tens_s), .borrow_out(b_min_tens_s)
  );

  // Next-state and ring-counter decode.
  always_comb begin
    state_nx = state_r;
    ring_nx  = ring_cnt_r;
    case (state_r)
      IDLE: begin
        if (!Stop && !Load && Start && !count_zero_s) state_nx = RUN;
        else                                          state_nx = IDLE;
      end
      RUN: begin
        if (Stop) begin
          state_nx = PAUSE;
        end else if (expire_s) begin
          state_nx = RING;
          ring_nx  = RING_LOAD;
        end else begin
          state_nx = RUN;
        end
      end
      PAUSE: begin
        if (Stop)                                     state_nx = IDLE;
        else if (!Load && Start && !count_zero_s)     state_nx = RUN;
        else                                          state_nx = PAUSE;
      end
      RING: begin
        if (Stop || (EN && (ring_cnt_r <= RING_W'(1)))) begin
          state_nx = IDLE;
          ring_nx  = '0;
        end else if (EN) begin
          ring_nx  = ring_cnt_r - RING_W'(1);
        end else begin
          ring_nx  = ring_cnt_r;
        end
      end
      default: begin
        state_nx = IDLE;
        ring_nx  = '0;
      end
    endcase
  end

  // State, ring counter and expiry pulse registers.
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      state_r    <= IDLE;
      ring_cnt_r <= '0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nx;
      ring_cnt_r <= ring_nx;
      done_r     <= expire_s;
    end
  end

  assign Min     = {min_tens_s, min_ones_s};
  assign Sec     = {sec_tens_s, sec_ones_s};
  assign Running = (state_r == RUN);
  assign Ring    = (state_r == RING);
  assign Done    = done_r;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer: each step pushes the expected
// {Min, Sec, Running, Ring, Done} and pops it once the DUT has updated.
module tb_bcd_countdown_timer;

  logic       CP = 1'b0;
  logic       nCR = 1'b1;
  logic       EN = 1'b0, Load = 1'b0, Start = 1'b0, Stop = 1'b0;
  logic [7:0] LoadMin = 8'h00, LoadSec = 8'h00;
  logic [7:0] Min, Sec;
  logic       Running, Ring, Done;

  int total = 0;
  int bad   = 0;
  logic [18:0] exp_q[$];
  logic [18:0] want, got;

  bcd_countdown_timer #(.RING_TICKS(30), .RING_W(8)) dut (
    .CP(CP), .nCR(nCR), .EN(EN), .Load(Load), .LoadMin(LoadMin), .LoadSec(LoadSec),
    .Start(Start), .Stop(Stop), .Min(Min), .Sec(Sec),
    .Running(Running), .Ring(Ring), .Done(Done)
  );

  always #5 CP = ~CP;

  function automatic logic [18:0] ex(input logic [7:0] m, input logic [7:0] s,
                                     input logic r, input logic g, input logic d);
    return {m, s, r, g, d};
  endfunction

  // Drive one cycle of inputs; returns 1 ns after the sampling edge.
  task automatic drive(input logic en, input logic ld, input logic st, input logic sp,
                       input logic [7:0] lm, input logic [7:0] ls);
    EN = en; Load = ld; Start = st; Stop = sp; LoadMin = lm; LoadSec = ls;
    @(posedge CP);
    #1;
    EN = 1'b0; Load = 1'b0; Start = 1'b0; Stop = 1'b0;
  endtask

  task automatic test_reset;
    nCR = 1'b0;
    #13;
    exp_q.push_back(ex(8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
    got = {Min, Sec, Running, Ring, Done};
    want = exp_q.pop_front();
    total++;
    if (got !== want) begin bad++; $display("FAIL reset_hold got=%h want=%h", got, want); end
    @(negedge CP);
    nCR = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(ex(8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      got = {Min, Sec, Running, Ring, Done};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin bad++; $display("FAIL idle_tick%0d got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_borrow;
    // {en, ld, st, sp, lm, ls}
    logic [19:0] stim[10];
    logic [18:0] expv[10];
    stim[0] = {4'b0100, 8'h10, 8'h00}; expv[0] = ex(8'h10, 8'h00, 1'b0, 1'b0, 1'b0);
    stim[1] = {4'b0010, 8'h00, 8'h00}; expv[1] = ex(8'h10, 8'h00, 1'b1, 1'b0, 1'b0);
    stim[2] = {4'b1000, 8'h00, 8'h00}; expv[2] = ex(8'h09, 8'h59, 1'b1, 1'b0, 1'b0);
    stim[3] = {4'b0001, 8'h00, 8'h00}; expv[3] = ex(8'h09, 8'h59, 1'b0, 1'b0, 1'b0);
    stim[4] = {4'b0001, 8'h00, 8'h00}; expv[4] = ex(8'h09, 8'h59, 1'b0, 1'b0, 1'b0);
    stim[5] = {4'b0100, 8'h01, 8'h00}; expv[5] = ex(8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    stim[6] = {4'b0010, 8'h00, 8'h00}; expv[6] = ex(8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
    stim[7] = {4'b1000, 8'h00, 8'h00}; expv[7] = ex(8'h00, 8'h59, 1'b1, 1'b0, 1'b0);
    stim[8] = {4'b0001, 8'h00, 8'h00}; expv[8] = ex(8'h00, 8'h59, 1'b0, 1'b0, 1'b0);
    stim[9] = {4'b0001, 8'h00, 8'h00}; expv[9] = ex(8'h00, 8'h59, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(expv[i]);
      drive(stim[i][19], stim[i][18], stim[i][17], stim[i][16], stim[i][15:8], stim[i][7:0]);
      got = {Min, Sec, Running, Ring, Done};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin bad++; $display("FAIL borrow_step%0d got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_expiry;
    int dones = 0;
    logic [19:0] stim[6];
    logic [18:0] expv[6];
    stim[0] = {4'b0100, 8'h00, 8'h03}; expv[0] = ex(8'h00, 8'h03, 1'b0, 1'b0, 1'b0);
    stim[1] = {4'b0010, 8'h00, 8'h00}; expv[1] = ex(8'h00, 8'h03, 1'b1, 1'b0, 1'b0);
    stim[2] = {4'b1000, 8'h00, 8'h00}; expv[2] = ex(8'h00, 8'h02, 1'b1, 1'b0, 1'b0);
    stim[3] = {4'b1000, 8'h00, 8'h00}; expv[3] = ex(8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
    stim[4] = {4'b1000, 8'h00, 8'h00}; expv[4] = ex(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    stim[5] = {4'b0000, 8'h00, 8'h00}; expv[5] = ex(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(expv[i]);
      drive(stim[i][19], stim[i][18], stim[i][17], stim[i][16], stim[i][15:8], stim[i][7:0]);
      if (Done === 1'b1) dones++;
      got = {Min, Sec, Running, Ring, Done};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin bad++; $display("FAIL expiry_step%0d got=%h want=%h", i, got, want); end
    end
    for (int t = 1; t <= 32; t++) begin
      exp_q.push_back(ex(8'h00, 8'h00, 1'b0, (t < 30), 1'b0));
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      if (Done === 1'b1) dones++;
      got = {Min, Sec, Running, Ring, Done};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin bad++; $display("FAIL ring_tick%0d got=%h want=%h", t, got, want); end
    end
    total++;
    if (dones !== 1) begin bad++; $display("FAIL done_count got=%0d want=1", dones); end
  endtask

  task automatic test_pause_resume;
    logic [19:0] stim[12];
    logic [18:0] expv[12];
    stim[0]  = {4'b0100, 8'h00, 8'h10}; expv[0]  = ex(8'h00, 8'h10, 1'b0, 1'b0, 1'b0);
    stim[1]  = {4'b0010, 8'h00, 8'h00}; expv[1]  = ex(8'h00, 8'h10, 1'b1, 1'b0, 1'b0);
    stim[2]  = {4'b1000, 8'h00, 8'h00}; expv[2]  = ex(8'h00, 8'h09, 1'b1, 1'b0, 1'b0);
    stim[3]  = {4'b1000, 8'h00, 8'h00}; expv[3]  = ex(8'h00, 8'h08, 1'b1, 1'b0, 1'b0);
    stim[4]  = {4'b1001, 8'h00, 8'h00}; expv[4]  = ex(8'h00, 8'h08, 1'b0, 1'b0, 1'b0);
    stim[5]  = {4'b1000, 8'h00, 8'h00}; expv[5]  = ex(8'h00, 8'h08, 1'b0, 1'b0, 1'b0);
    stim[6]  = {4'b1000, 8'h00, 8'h00}; expv[6]  = ex(8'h00, 8'h08, 1'b0, 1'b0, 1'b0);
    stim[7]  = {4'b1000, 8'h00, 8'h00}; expv[7]  = ex(8'h00, 8'h08, 1'b0, 1'b0, 1'b0);
    stim[8]  = {4'b0010, 8'h00, 8'h00}; expv[8]  = ex(8'h00, 8'h08, 1'b1, 1'b0, 1'b0);
    stim[9]  = {4'b1000, 8'h00, 8'h00}; expv[9]  = ex(8'h00, 8'h07, 1'b1, 1'b0, 1'b0);
    stim[10] = {4'b0001, 8'h00, 8'h00}; expv[10] = ex(8'h00, 8'h07, 1'b0, 1'b0, 1'b0);
    stim[11] = {4'b0001, 8'h00, 8'h00}; expv[11] = ex(8'h00, 8'h07, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(expv[i]);
      drive(stim[i][19], stim[i][18], stim[i][17], stim[i][16], stim[i][15:8], stim[i][7:0]);
      got = {Min, Sec, Running, Ring, Done};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin bad++; $display("FAIL pause_step%0d got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_priority;
    logic [19:0] stim[7];
    logic [18:0] expv[7];
    stim[0] = {4'b0110, 8'h2A, 8'h7C}; expv[0] = ex(8'h29, 8'h59, 1'b0, 1'b0, 1'b0);
    stim[1] = {4'b0100, 8'h00, 8'h00}; expv[1] = ex(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    stim[2] = {4'b0010, 8'h00, 8'h00}; expv[2] = ex(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    stim[3] = {4'b0100, 8'h00, 8'h01}; expv[3] = ex(8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
    stim[4] = {4'b0010, 8'h00, 8'h00}; expv[4] = ex(8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
    stim[5] = {4'b1000, 8'h00, 8'h00}; expv[5] = ex(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    stim[6] = {4'b0001, 8'h00, 8'h00}; expv[6] = ex(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(expv[i]);
      drive(stim[i][19], stim[i][18], stim[i][17], stim[i][16], stim[i][15:8], stim[i][7:0]);
      got = {Min, Sec, Running, Ring, Done};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin bad++; $display("FAIL prio_step%0d got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_async_reset;
    logic [18:0] expv[6];
    expv[0] = ex(8'h05, 8'h00, 1'b0, 1'b0, 1'b0);
    expv[1] = ex(8'h05, 8'h00, 1'b1, 1'b0, 1'b0);
    expv[2] = ex(8'h04, 8'h59, 1'b1, 1'b0, 1'b0);
    expv[3] = ex(8'h04, 8'h58, 1'b1, 1'b0, 1'b0);
    expv[4] = ex(8'h04, 8'h57, 1'b1, 1'b0, 1'b0);
    expv[5] = ex(8'h04, 8'h56, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(expv[i]);
      drive(i >= 2, i == 0, i == 1, 1'b0, 8'h05, 8'h00);
      got = {Min, Sec, Running, Ring, Done};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin bad++; $display("FAIL arst_step%0d got=%h want=%h", i, got, want); end
    end
    #1;
    nCR = 1'b0;
    exp_q.push_back(ex(8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
    #1;
    got = {Min, Sec, Running, Ring, Done};
    want = exp_q.pop_front();
    total++;
    if (got !== want) begin bad++; $display("FAIL arst_clear got=%h want=%h", got, want); end
    @(negedge CP);
    nCR = 1'b1;
    exp_q.push_back(ex(8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    got = {Min, Sec, Running, Ring, Done};
    want = exp_q.pop_front();
    total++;
    if (got !== want) begin bad++; $display("FAIL arst_after got=%h want=%h", got, want); end
  endtask

  initial begin
    test_reset();
    test_borrow();
    test_expiry();
    test_pause_resume();
    test_priority();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
